// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: opcode map, FSM states and the
// helper that tells which opcodes take the iterative path.
// Optional feature macro: ALU_MC_FLAGS_EN (adds the flags output on alu_mc).
package alu_mc_pkg;

  // 4-bit opcode map, identical to the original combinational ALU
  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_DIV  = 4'h3,
    OP_MOD  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_NOT  = 4'h7,
    OP_XOR  = 4'h8,
    OP_SLT  = 4'h9,
    OP_SGT  = 4'hA,
    OP_SLET = 4'hB,
    OP_SGET = 4'hC,
    OP_LSH  = 4'hD,
    OP_RSH  = 4'hE,
    OP_RSVD = 4'hF
  } alu_op_e;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } alu_state_e;

  // MUL, DIV and MOD go through the bit-serial unit; everything else is one cycle
  function automatic logic is_iterative(input alu_op_e op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Bit-serial multiply / restoring divide engine shared by MUL, DIV and MOD.
// One operand bit is consumed per clock, MSB first. Multiply is shift-add
// (acc = 2*acc + bit*b, keeping the low WIDTH bits); divide shifts the
// dividend into a partial remainder and subtracts the divisor when it fits.
// o_done is asserted in the cycle whose clock edge performs the final step;
// o_result / o_remainder then carry the values that step produces, so the
// caller can register them on that same edge.
// Divide by zero falls out naturally: every trial subtraction succeeds, the
// quotient becomes all ones and the remainder ends up equal to the dividend.
// Optional feature macro of the enclosing design: ALU_MC_FLAGS_EN (unused here).
module alu_mc_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_op_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic [WIDTH-1:0] r_acc;   // product accumulator / partial remainder
  logic [WIDTH-1:0] r_sh;    // multiplier / dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] r_b;     // multiplicand / divisor

  logic             w_busy;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_sh_next;

  assign w_busy = (r_cnt != '0);
  assign o_done = (r_cnt == CNT_W'(1));

  // Trial subtraction one bit wider than the operands; its MSB is the borrow
  assign w_trial = {r_acc, r_sh[WIDTH-1]};
  assign w_diff  = w_trial - {1'b0, r_b};

  // One iteration step for either multiply or divide
  always_comb begin
    w_acc_next = r_acc;
    w_sh_next  = r_sh;
    if (r_is_div) begin
      if (!w_diff[WIDTH]) begin
        w_acc_next = w_diff[WIDTH-1:0];
        w_sh_next  = {r_sh[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_next = w_trial[WIDTH-1:0];
        w_sh_next  = {r_sh[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_acc_next = {r_acc[WIDTH-2:0], 1'b0} + (r_sh[WIDTH-1] ? r_b : '0);
      w_sh_next  = {r_sh[WIDTH-2:0], 1'b0};
    end
  end

  assign o_result    = r_is_div ? w_sh_next : w_acc_next;
  assign o_remainder = w_acc_next;

  // Load operands on start, then step once per clock until the counter drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_acc    <= '0;
      r_sh     <= '0;
      r_b      <= '0;
    end else if (i_start) begin
      r_cnt    <= CNT_W'(WIDTH);
      r_is_div <= i_op_is_div;
      r_acc    <= '0;
      r_sh     <= i_a;
      r_b      <= i_b;
    end else if (w_busy) begin
      r_cnt    <= r_cnt - CNT_W'(1);
      r_acc    <= w_acc_next;
      r_sh     <= w_sh_next;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU for the EX stage. Requests and results travel over
// valid/ready handshakes; single-cycle ops are registered on the accept edge,
// MUL/DIV/MOD are handed to the bit-serial engine and finish WIDTH clocks later.
// The result register only moves when a new result is produced, which happens
// only after the previous one was accepted, so out stays stable while valid.
// Optional feature macro: ALU_MC_FLAGS_EN adds flags[0:3] = {zero, carry,
// overflow, divzero}, registered together with out.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluctrl,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
`ifdef ALU_MC_FLAGS_EN
  ,
  output logic [0:3]       flags
`endif
);

  alu_state_e       r_state;
  alu_state_e       w_state_next;
  alu_state_e       w_target;
  alu_op_e          w_op;
  logic             w_accept;
  logic             w_single_load;
  logic             w_iter_start;
  logic             w_iter_load;
  logic             w_iter_done;
  logic [WIDTH-1:0] w_iter_res;
  logic [WIDTH-1:0] w_iter_rem;
  logic [WIDTH-1:0] w_iter_out;
  logic [WIDTH-1:0] w_single;
  logic [WIDTH-1:0] w_add;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] r_out;
  logic             r_is_mod;

  assign w_op          = alu_op_e'(aluctrl);
  assign w_accept      = in_valid & in_ready;
  assign w_single_load = w_accept & ~is_iterative(w_op);
  assign w_iter_start  = w_accept & is_iterative(w_op);
  assign w_iter_load   = w_iter_done & ((r_state == ST_MUL) | (r_state == ST_DIV));
  assign w_iter_out    = r_is_mod ? w_iter_rem : w_iter_res;

  // Add/sub share their carry-extended forms with the flag logic when present
`ifdef ALU_MC_FLAGS_EN
  logic [WIDTH:0] w_add_ext;
  logic [WIDTH:0] w_sub_ext;
  assign w_add_ext = {1'b0, in1} + {1'b0, in2};
  assign w_sub_ext = {1'b0, in1} - {1'b0, in2};
  assign w_add     = w_add_ext[WIDTH-1:0];
  assign w_sub     = w_sub_ext[WIDTH-1:0];
`else
  assign w_add     = in1 + in2;
  assign w_sub     = in1 - in2;
`endif

  alu_mc_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_iter_start),
    .i_op_is_div (w_op != OP_MUL),
    .i_a         (in1),
    .i_b         (in2),
    .o_done      (w_iter_done),
    .o_result    (w_iter_res),
    .o_remainder (w_iter_rem)
  );

  // Single-cycle result mux; compares are unsigned, shifts saturate to 0
  always_comb begin
    w_single = '0;
    case (w_op)
      OP_ADD:  w_single = w_add;
      OP_SUB:  w_single = w_sub;
      OP_AND:  w_single = in1 & in2;
      OP_OR:   w_single = in1 | in2;
      OP_NOT:  w_single = ~in1;
      OP_XOR:  w_single = in1 ^ in2;
      OP_SLT:  w_single = WIDTH'(in1 <  in2);
      OP_SGT:  w_single = WIDTH'(in1 >  in2);
      OP_SLET: w_single = WIDTH'(in1 <= in2);
      OP_SGET: w_single = WIDTH'(in1 >= in2);
      OP_LSH:  w_single = (in2 >= WIDTH'(WIDTH)) ? '0 : (in1 << in2);
      OP_RSH:  w_single = (in2 >= WIDTH'(WIDTH)) ? '0 : (in1 >> in2);
      default: w_single = '0;
    endcase
  end

  // State after accepting the opcode currently on aluctrl
  always_comb begin
    w_target = ST_DONE;
    if (w_op == OP_MUL) begin
      w_target = ST_MUL;
    end else if (is_iterative(w_op)) begin
      w_target = ST_DIV;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_next = w_target;
      end
      ST_MUL, ST_DIV: begin
        if (w_iter_done) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        if (w_accept) begin
          w_state_next = w_target;
        end else if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake signals
  always_comb begin
    in_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
    out_valid = (r_state == ST_DONE);
  end

  // Result register plus the DIV/MOD selector latched at accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out    <= '0;
      r_is_mod <= 1'b0;
    end else begin
      if (w_accept) r_is_mod <= (w_op == OP_MOD);
      if (w_single_load) begin
        r_out <= w_single;
      end else if (w_iter_load) begin
        r_out <= w_iter_out;
      end
    end
  end

  assign out = r_out;

`ifdef ALU_MC_FLAGS_EN
  logic [0:3] r_flags;
  logic [0:3] w_single_flags;
  logic [0:3] w_iter_flags;
  logic       r_divzero;
  logic       w_add_ovf;
  logic       w_sub_ovf;

  // Two's-complement overflow: sign of result disagrees with what the operand signs allow
  assign w_add_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) & (w_add[WIDTH-1] != in1[WIDTH-1]);
  assign w_sub_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) & (w_sub[WIDTH-1] != in1[WIDTH-1]);

  // Flags for a single-cycle result; carry/overflow only meaningful for add/sub
  always_comb begin
    w_single_flags    = '0;
    w_single_flags[0] = (w_single == '0);
    if (w_op == OP_ADD) begin
      w_single_flags[1] = w_add_ext[WIDTH];
      w_single_flags[2] = w_add_ovf;
    end else if (w_op == OP_SUB) begin
      w_single_flags[1] = w_sub_ext[WIDTH];
      w_single_flags[2] = w_sub_ovf;
    end
  end

  assign w_iter_flags = {(w_iter_out == '0), 1'b0, 1'b0, r_divzero};

  // Flag register, loaded on exactly the same edges as the result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags   <= '0;
      r_divzero <= 1'b0;
    end else begin
      if (w_accept) r_divzero <= is_iterative(w_op) & (w_op != OP_MUL) & (in2 == '0);
      if (w_single_load) begin
        r_flags <= w_single_flags;
      end else if (w_iter_load) begin
        r_flags <= w_iter_flags;
      end
    end
  end

  assign flags = r_flags;
`endif

endmodule
